// File: rtl/debounce_edge.sv
// rtl/debounce_edge.sv - synchronizing debouncer with level output and edge strobes
//
// Purpose: brings a raw asynchronous input into the CLK domain through a
// SYNC_STAGES-deep flop chain, requires STABLE_CYCLES consecutive equal
// synchronized samples before the debounced level moves, and counts aborted
// candidate transitions in a saturating 8-bit counter.
//
// Ports:
//   CLK      in   system clock, rising edge
//   RST_N    in   synchronous active-low reset
//   D        in   raw asynchronous input
//   Q        out  debounced level (registered)
//   RISE     out  one-cycle strobe on a Q 0->1 change (registered)
//   FALL     out  one-cycle strobe on a Q 1->0 change (registered)
//   BUSY     out  a candidate transition is being qualified
//   GLITCHES out  saturating count of aborted transitions
module debounce_edge #(
  parameter int       SYNC_STAGES   = 2,
  parameter int       STABLE_CYCLES = 4,
  parameter int       CNT_WIDTH     = 16,
  parameter logic     RESET_LEVEL   = 1'b0
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       D,
  output logic       Q,
  output logic       RISE,
  output logic       FALL,
  output logic       BUSY,
  output logic [7:0] GLITCHES
);

  localparam logic [1:0] ST_STABLE_LO = 2'd0;
  localparam logic [1:0] ST_WAIT_HI   = 2'd1;
  localparam logic [1:0] ST_STABLE_HI = 2'd2;
  localparam logic [1:0] ST_WAIT_LO   = 2'd3;

  localparam logic [1:0] ST_RESET = RESET_LEVEL ? ST_STABLE_HI : ST_STABLE_LO;

  // Terminal count: the sample that lands here is the STABLE_CYCLES-th one.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [1:0]             state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   q_q, q_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic [7:0]             glitch_q, glitch_d;
  logic [7:0]             glitch_inc;
  logic                   sd;

  assign sync_d     = {sync_q[SYNC_STAGES-2:0], D};
  assign sd         = sync_q[SYNC_STAGES-1];
  assign glitch_inc = (glitch_q == 8'hFF) ? glitch_q : glitch_q + 8'd1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    q_d      = q_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    glitch_d = glitch_q;
    case (state_q)
      ST_STABLE_LO: begin
        if (sd) begin
          state_d = ST_WAIT_HI;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      ST_WAIT_HI: begin
        if (!sd) begin
          // Falling back to the current level, even on the last sample, is an abort.
          state_d  = ST_STABLE_LO;
          cnt_d    = '0;
          glitch_d = glitch_inc;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_STABLE_HI;
          cnt_d   = '0;
          q_d     = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_STABLE_HI: begin
        if (!sd) begin
          state_d = ST_WAIT_LO;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      ST_WAIT_LO: begin
        if (sd) begin
          state_d  = ST_STABLE_HI;
          cnt_d    = '0;
          glitch_d = glitch_inc;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_STABLE_LO;
          cnt_d   = '0;
          q_d     = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_RESET;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync_q   <= {SYNC_STAGES{RESET_LEVEL}};
      state_q  <= ST_RESET;
      cnt_q    <= '0;
      q_q      <= RESET_LEVEL;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= 8'd0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      q_q      <= q_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
    end
  end

  assign Q        = q_q;
  assign RISE     = rise_q;
  assign FALL     = fall_q;
  assign BUSY     = (state_q == ST_WAIT_HI) || (state_q == ST_WAIT_LO);
  assign GLITCHES = glitch_q;

endmodule

// File: tb/tb_debounce_edge.sv
// tb/tb_debounce_edge.sv - directed table-driven bench for debounce_edge
module tb_debounce_edge;

  logic       CLK;
  logic       RST_N;
  logic       D;
  logic       Q;
  logic       RISE;
  logic       FALL;
  logic       BUSY;
  logic [7:0] GLITCHES;

  int checks;
  int failures;

  debounce_edge dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .D        (D),
    .Q        (Q),
    .RISE     (RISE),
    .FALL     (FALL),
    .BUSY     (BUSY),
    .GLITCHES (GLITCHES)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One record = inputs held across one rising edge, outputs expected just after it.
  typedef struct packed {
    logic       rst_n;
    logic       d;
    logic       q;
    logic       rise;
    logic       fall;
    logic       busy;
    logic [7:0] glitches;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst_n, input logic d, input logic q, input logic rise,
                     input logic fall, input logic busy, input logic [7:0] g);
    vec_t v;
    v.rst_n = rst_n; v.d = d; v.q = q; v.rise = rise;
    v.fall = fall; v.busy = busy; v.glitches = g;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (q,rise,fall,busy,glitches)", name, act, exp);
    end
  endtask

  function automatic logic [11:0] outs();
    return {Q, RISE, FALL, BUSY, GLITCHES};
  endfunction

  // Apply inputs, cross one rising edge, settle 1 time unit past it.
  task automatic step(input logic rst_n, input logic d);
    RST_N = rst_n;
    D     = d;
    @(posedge CLK);
    #1;
    checks++;
    if (RISE && FALL) begin
      failures++;
      $display("FAIL dual_strobe actual=%b%b required=not both", RISE, FALL);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    RST_N    = 1'b0;
    D        = 1'b0;
    @(negedge CLK);

    // Reset with D=1, then release: Q rises on release-edge+5.
    add(0,1, 0,0,0,0,0); add(0,1, 0,0,0,0,0); add(0,1, 0,0,0,0,0);
    add(1,1, 0,0,0,0,0); add(1,1, 0,0,0,0,0);
    add(1,1, 0,0,0,1,0); add(1,1, 0,0,0,1,0); add(1,1, 0,0,0,1,0);
    add(1,1, 1,1,0,0,0); add(1,1, 1,0,0,0,0);
    // Clean fall from Q=1.
    add(1,0, 1,0,0,0,0); add(1,0, 1,0,0,0,0);
    add(1,0, 1,0,0,1,0); add(1,0, 1,0,0,1,0); add(1,0, 1,0,0,1,0);
    add(1,0, 0,0,1,0,0); add(1,0, 0,0,0,0,0);
    // 2-cycle glitch.
    add(1,1, 0,0,0,0,0); add(1,1, 0,0,0,0,0);
    add(1,0, 0,0,0,1,0); add(1,0, 0,0,0,1,0);
    add(1,0, 0,0,0,0,1); add(1,0, 0,0,0,0,1);
    // 3-cycle pulse: aborts on the final WAIT sample.
    add(1,1, 0,0,0,0,1); add(1,1, 0,0,0,0,1); add(1,1, 0,0,0,1,1);
    add(1,0, 0,0,0,1,1); add(1,0, 0,0,0,1,1);
    add(1,0, 0,0,0,0,2); add(1,0, 0,0,0,0,2);
    // Clean rise from idle with glitch count preserved.
    add(1,1, 0,0,0,0,2); add(1,1, 0,0,0,0,2);
    add(1,1, 0,0,0,1,2); add(1,1, 0,0,0,1,2); add(1,1, 0,0,0,1,2);
    add(1,1, 1,1,0,0,2); add(1,1, 1,0,0,0,2);
    // 2-cycle low glitch while high.
    add(1,0, 1,0,0,0,2); add(1,0, 1,0,0,0,2);
    add(1,1, 1,0,0,1,2); add(1,1, 1,0,0,1,2);
    add(1,1, 1,0,0,0,3); add(1,1, 1,0,0,0,3);
    // Clean fall back to Q=0.
    add(1,0, 1,0,0,0,3); add(1,0, 1,0,0,0,3);
    add(1,0, 1,0,0,1,3); add(1,0, 1,0,0,1,3); add(1,0, 1,0,0,1,3);
    add(1,0, 0,0,1,0,3); add(1,0, 0,0,0,0,3);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst_n, vecs[i].d);
      check($sformatf("vec%0d", i), outs(),
            {vecs[i].q, vecs[i].rise, vecs[i].fall, vecs[i].busy, vecs[i].glitches});
    end

    // Saturation: 300 one-cycle-high pulses, input toggling every cycle.
    begin
      int saw_edge;
      saw_edge = 0;
      for (int i = 0; i < 300; i++) begin
        step(1, 1);
        if (RISE || FALL || Q) saw_edge++;
        step(1, 0);
        if (RISE || FALL || Q) saw_edge++;
      end
      step(1, 0); step(1, 0); step(1, 0);
      check("sat_glitches", {4'b0, GLITCHES}, 12'd255);
      check("sat_q_quiet", 12'(saw_edge), 12'd0);
      for (int i = 0; i < 10; i++) begin
        step(1, 1); step(1, 0);
      end
      step(1, 0); step(1, 0);
      check("sat_hold", outs(), {4'b0000, 8'd255});
    end

    // Reset mid-WAIT: transition discarded, count cleared, requalifies after release.
    begin
      int rise_cnt;
      step(1, 1);                         // edge k
      step(1, 1);                         // k+1
      step(1, 1);                         // k+2
      check("midwait_busy", outs(), {4'b0001, 8'd255});
      step(0, 1);                         // k+3, reset asserted
      check("midwait_reset", outs(), {4'b0000, 8'd0});
      rise_cnt = 0;
      for (int i = 0; i < 5; i++) begin   // release-edge .. release-edge+4
        step(1, 1);
        if (RISE || Q) rise_cnt++;
      end
      check("midwait_early_rise", 12'(rise_cnt), 12'd0);
      step(1, 1);                         // release-edge+5
      check("midwait_requal", outs(), {4'b1100, 8'd0});
      step(1, 1);
      check("midwait_rise_drop", outs(), {4'b1000, 8'd0});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/debounce_edge.md
Name: debounce_edge

Overview:
- Conditioning stage placed directly upstream of the flip-flop-based storage elements in the lab datapath.
- Takes a raw asynchronous input such as a push-button or external pulse line and passes it through a synchronizer chain.
- Filters it with a stability counter and state machine, then drives a clean level plus single-cycle rising and falling strobes.
- Downstream D-input registers consume these outputs directly.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on D; legal values are 2 or more.
- STABLE_CYCLES, 4, number of consecutive synchronized samples required before Q changes; legal range is 2 to 2^CNT_WIDTH-1.
- CNT_WIDTH, 16, width of the stability counter.
- RESET_LEVEL, 0, value that Q and the synchronizer flops take in reset.

Ports:
- CLK  input  1  single system clock; all state updates on the rising edge.
- RST_N  input  1  reset, synchronous, active-low.
- D  input  1  raw asynchronous input.
- Q  output  1  debounced level, registered.
- RISE  output  1  one-cycle strobe on a Q 0->1 transition, registered.
- FALL  output  1  one-cycle strobe on a Q 1->0 transition, registered.
- BUSY  output  1  high while a candidate transition is being qualified.
- GLITCHES  output  8  saturating count of aborted transitions.

Behaviour:
- Reset:
  - RST_N is sampled on the CLK rising edge and has priority over all other logic.
  - While RST_N=0: all sync flops = RESET_LEVEL, Q = RESET_LEVEL, RISE = FALL = 0, BUSY = 0, GLITCHES = 0, counter = 0.
  - State = STABLE_LO if RESET_LEVEL=0, otherwise STABLE_HI.
- Synchronizer:
  - Shift chain: D -> s[0] -> ... -> s[SYNC_STAGES-1].
  - The FSM sees only the last stage, called sd.
- FSM states: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
  - STABLE_LO:
    - sd=1 -> WAIT_HI, counter = 1.
    - Otherwise hold, counter = 0.
  - WAIT_HI:
    - sd=0 -> STABLE_LO, counter = 0, GLITCHES += 1 (saturate at 255), Q unchanged, no strobe.
    - sd=1 and counter = STABLE_CYCLES-1 -> STABLE_HI, Q = 1, RISE = 1, counter = 0.
    - sd=1 otherwise -> counter += 1.
  - STABLE_HI and WAIT_LO mirror the above with polarities swapped; the qualified transition sets Q = 0 and FALL = 1.
- Latency:
  - Condition: D changes and is held stable before edge k.
  - Q, RISE or FALL update on edge k + SYNC_STAGES + STABLE_CYCLES - 1.
  - With defaults this is edge k+5.
- Strobes:
  - RISE and FALL are high for exactly one cycle, registered on the same edge as the Q change.
  - They deassert on the next edge unconditionally.
  - RISE and FALL are never high simultaneously.
- BUSY: combinational decode of state, high in WAIT_HI and WAIT_LO only.
- Arithmetic:
  - The counter never exceeds STABLE_CYCLES-1 and never wraps.
  - GLITCHES holds at 255 once reached.
- Boundary conditions:
  - Input toggling every cycle: Q never changes, and GLITCHES increments once per abort.
  - Abort and re-qualify: sd returning to the Q level in the final WAIT cycle counts as an abort. Re-qualification restarts from counter = 1 on the next opposite sample.
  - Reset mid-WAIT: the transition is discarded and GLITCHES is cleared, not incremented.
  - Reset with D opposite to RESET_LEVEL: after release, qualification starts normally. No strobe is asserted during reset.

Test Plan:
- Reset with defaults: hold RST_N=0 for 3 cycles with D=1 -> Q=0, RISE=0, GLITCHES=0 throughout. Release with D still 1 -> Q=1 and RISE=1 for one cycle on release-edge+5.
- Clean rise: D 0->1 before edge k, held -> BUSY=1 from edge k+2 to k+4, Q=1 and RISE=1 after edge k+5, RISE=0 after edge k+6, GLITCHES unchanged.
- Clean fall: from Q=1, D 1->0 before edge k -> Q=0 and FALL=1 after edge k+5, RISE stays 0.
- Glitch: D=1 for 2 cycles then back to 0 -> Q stays 0, no strobes, GLITCHES=1, BUSY returns to 0. A 3-cycle pulse likewise aborts (it needs 4 samples), giving GLITCHES=2.
- Saturation: 300 back-to-back 1-cycle-high pulses -> GLITCHES=255 and holds, Q=0.
- Reset mid-WAIT: D 0->1, assert RST_N=0 at edge k+3 for 1 cycle, keep D=1 -> no RISE during reset, GLITCHES=0, Q=1 on release-edge+5.
